// File: rtl/fpadd_pkg.sv
// Shared types for the FP adder sharing controller and the adder datapath.
package fpadd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float32_t;

endpackage

// File: rtl/fpadd_share_ctrl_if.sv
// Requester-side operand and response handshakes of the shared FP adder.
interface fpadd_share_ctrl_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [31:0]           rsp_result;
    logic                  rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/fpadd_rr_pick.sv
// Round-robin search: first valid requester at or above rr_ptr, wrapping.
module fpadd_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);
    logic          found;
    logic [IW-1:0] sel;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            sel = IW'(idx);
            if (!found && req_valid[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end
endmodule

// File: rtl/fpadd_share_ctrl.sv
// Round-robin sharing of one multi-cycle FP adder with start/done
// sequencing and a watchdog that answers a quiet NaN on a lost done.
module fpadd_share_ctrl
    import fpadd_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    fpadd_share_ctrl_if.slave   bus,
    output logic                add_start,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    input  logic                add_done,
    input  logic [31:0]         add_result,
    output logic                busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   grant_idx;
    logic [NREQ-1:0] grant;
    logic [CW-1:0]   cnt;
    float32_t        op_a;
    float32_t        op_b;
    logic [31:0]     result;
    logic            err;
    logic            timeout;
    logic            rsp_fire;
    logic [IW-1:0]   ptr_nx;

    fpadd_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign timeout  = (cnt == CW'(TIMEOUT - 1));
    assign rsp_fire = bus.rsp_ready[owner];
    assign ptr_nx   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    assign add_a          = op_a;
    assign add_b          = op_b;
    assign bus.rsp_result = result;
    assign bus.rsp_err    = err;

    always_comb begin
        state_nx      = state;
        add_start     = 1'b0;
        busy          = (state != IDLE);
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        unique case (state)
            IDLE: begin
                // Keep ready low while reset is held so no handshake is seen.
                if (!reset) bus.req_ready = grant;
                if (|grant) state_nx = ISSUE;
            end
            ISSUE: begin
                add_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (add_done || timeout) state_nx = RESP;
            end
            RESP: begin
                bus.rsp_valid[owner] = 1'b1;
                if (rsp_fire) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        op_a  <= bus.req_a[grant_idx];
                        op_b  <= bus.req_b[grant_idx];
                        owner <= grant_idx;
                        cnt   <= '0;
                    end
                end
                ISSUE: begin
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A done arriving with the timeout still counts as success.
                    if (add_done) begin
                        result <= add_result;
                        err    <= 1'b0;
                    end else if (timeout) begin
                        result <= FP_QNAN;
                        err    <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_fire) rr_ptr <= ptr_nx;
                end
            endcase
        end
    end
endmodule
